// File: rtl/aes_pkg.sv
// Shared types for the AES cipher feeder: block type, feeder FSM states
// and fixed widths.
package aes_pkg;

  localparam int BLK_W = 128;
  localparam int CNT_W = 16;

  typedef logic [BLK_W-1:0] blk_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/aes_blk_fifo.sv
// Power-of-two block FIFO with an extra wrap bit on each pointer to tell
// full from empty; head entry is visible combinationally on rdata.
module aes_blk_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  blk_t wdata,
  output blk_t rdata,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  blk_t          mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/aes_cipher_feeder.sv
// Feeds buffered plaintext blocks one at a time into an external AES core,
// captures each result into a single output slot, and flags missing done pulses.
module aes_cipher_feeder
  import aes_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  blk_t             key,
  input  logic             in_valid,
  output logic             in_ready,
  input  blk_t             in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output blk_t             out_data,
  output logic             core_ld,
  output blk_t             core_key,
  output blk_t             core_text_in,
  input  logic             core_done,
  input  blk_t             core_text_out,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] blk_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);

  feeder_state_t state, state_nxt;
  logic          fifo_full, fifo_empty;
  blk_t          fifo_head;
  logic          launch, timeout;
  logic [TW-1:0] tmr;

  assign in_ready = !fifo_full;

  aes_blk_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid && in_ready),
    .pop   (launch),
    .wdata (in_data),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    timeout   = 1'b0;
    unique case (state)
      IDLE: if (!fifo_empty && (!out_valid || out_ready)) begin
        launch    = 1'b1;
        state_nxt = LOAD;
      end
      LOAD: state_nxt = RUN;
      RUN: begin
        if (core_done) begin
          state_nxt = IDLE;
        end else if (tmr == TW'(TIMEOUT - 1)) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Launch only when the output slot is free or draining, so a capture never
  // lands on an undelivered result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_ld      <= 1'b0;
      core_key     <= '0;
      core_text_in <= '0;
      tmr          <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      blk_cnt      <= '0;
      err          <= 1'b0;
    end else begin
      core_ld <= launch;
      if (launch) begin
        core_key     <= key;
        core_text_in <= fifo_head;
        tmr          <= '0;
      end else if (state != IDLE) begin
        tmr <= tmr + TW'(1);
      end

      if (timeout) err <= 1'b1;

      if (state == RUN && core_done) begin
        out_data  <= core_text_out;
        out_valid <= 1'b1;
        blk_cnt   <= blk_cnt + CNT_W'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE) || !fifo_empty || out_valid;

endmodule
